// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial frame transmitter feeding a "011" sequence detector.
//            Accepts a payload word over valid/ready and sends a frame:
//            sync pattern (MSB first), payload (MSB first), optional even
//            parity bit, then a fixed idle gap. Each bit is held for
//            CLKS_PER_BIT clocks.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous, active-high reset
//            in_data    - payload word, captured on accept
//            in_valid   - producer has a word
//            in_ready   - block can accept (IDLE and not in reset)
//            outs       - registered serial line
//            busy       - high whenever a frame or gap is in progress
//            frame_done - one-cycle pulse when frame plus gap completes
// Config   : define SEQ_TX_PARITY_EN to append an even parity bit after
//            the payload.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int                    DATA_W       = 8,
  parameter int                    SYNC_LEN     = 3,
  parameter logic [SYNC_LEN-1:0]   SYNC_PAT     = 3'b011,
  parameter int                    CLKS_PER_BIT = 4,
  parameter int                    GAP_BITS     = 2,
  parameter logic                  IDLE_LVL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              outs,
  output logic              busy,
  output logic              frame_done
);

  // Bit counter covers the longest run of bits spent in one state.
  localparam int c_max_bits = (SYNC_LEN > DATA_W)
                              ? ((SYNC_LEN > GAP_BITS) ? SYNC_LEN : GAP_BITS)
                              : ((DATA_W   > GAP_BITS) ? DATA_W   : GAP_BITS);
  localparam int c_bit_w    = $clog2(c_max_bits + 1);
  localparam int c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0] c_sync_last = c_bit_w'(SYNC_LEN - 1);
  localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_W - 1);
  localparam logic [c_bit_w-1:0] c_gap_last  =
      (GAP_BITS > 0) ? c_bit_w'(GAP_BITS - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_bit_w-1:0]   r_bit;
  logic [SYNC_LEN-1:0]  r_sync;
  logic [DATA_W-1:0]    r_shift;
  logic                 r_outs;
  logic                 r_busy;
  logic                 r_done;
`ifdef SEQ_TX_PARITY_EN
  logic                 r_par;
`endif

  logic w_bit_end;
  logic w_last_payload;

  assign w_bit_end = (r_cnt == c_cnt_last);

  // Final bit-time of the payload section (parity bit when enabled).
`ifdef SEQ_TX_PARITY_EN
  assign w_last_payload = (r_state == S_PARITY) && w_bit_end;
`else
  assign w_last_payload = (r_state == S_DATA) && w_bit_end &&
                          (r_bit == c_data_last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sync  <= '0;
      r_shift <= '0;
      r_outs  <= IDLE_LVL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      // Bit-time counter runs in every non-idle state and wraps per bit.
      if (r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // First sync bit goes straight onto the line so it appears in
            // the cycle after accept; the remaining sync bits queue behind.
            r_state <= S_SYNC;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_outs  <= SYNC_PAT[SYNC_LEN-1];
            r_sync  <= SYNC_PAT << 1;
            r_shift <= in_data;
`ifdef SEQ_TX_PARITY_EN
            r_par   <= ^in_data;
`endif
          end
        end

        S_SYNC: begin
          if (w_bit_end) begin
            if (r_bit == c_sync_last) begin
              r_state <= S_DATA;
              r_bit   <= '0;
              r_outs  <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_outs <= r_sync[SYNC_LEN-1];
              r_sync <= r_sync << 1;
            end
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == c_data_last) begin
`ifdef SEQ_TX_PARITY_EN
              r_state <= S_PARITY;
              r_bit   <= '0;
              r_outs  <= r_par;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_outs  <= r_shift[DATA_W-1];
              r_shift <= r_shift << 1;
            end
          end
        end

`ifdef SEQ_TX_PARITY_EN
        S_PARITY: begin
          // Exit handled by the payload-end logic below.
        end
`endif

        S_GAP: begin
          if (w_bit_end) begin
            if (r_bit == c_gap_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_outs  <= IDLE_LVL;
        end
      endcase

      // Leaving the payload: into the gap, or straight home when there is
      // no gap so back-to-back frames keep their cadence.
      if (w_last_payload) begin
        r_outs <= IDLE_LVL;
        r_bit  <= '0;
        if (GAP_BITS > 0) begin
          r_state <= S_GAP;
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign outs       = r_outs;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx. Instance A uses the
//            default parameters; instance B uses CLKS_PER_BIT=1, GAP_BITS=0.
//            Expected line values come from a frame-level model built from
//            the frame format (sync, payload, optional parity, gap).
// Config   : honours SEQ_TX_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data,  b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_outs,  b_outs;
  logic       a_busy,  b_busy;
  logic       a_done,  b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_data    (a_data),
    .in_valid   (a_valid),
    .in_ready   (a_ready),
    .outs       (a_outs),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  seq_pattern_tx #(
    .CLKS_PER_BIT (1),
    .GAP_BITS     (0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_data    (b_data),
    .in_valid   (b_valid),
    .in_ready   (b_ready),
    .outs       (b_outs),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  // Completion cycle relative to the accept cycle.
  function automatic int t_done(input int sel);
    return 1 + (3 + 8 + PAR + gap_of(sel)) * cpb_of(sel);
  endfunction

  // Expected line level k cycles after accept.
  function automatic logic exp_line(input int sel, input logic [7:0] d, input int k);
    logic [2:0] sp;
    int b;
    sp = 3'b011;
    b  = (k - 1) / cpb_of(sel);
    if (b < 3)                return sp[2-b];
    if (b < 11)               return d[7-(b-3)];
    if (PAR == 1 && b == 11)  return ^d;
    return 1'b1;
  endfunction

  // ---------------- DUT access ----------------
  function automatic logic [31:0] o_outs(input int sel);
    return 32'((sel == 0) ? a_outs : b_outs);
  endfunction
  function automatic logic [31:0] o_busy(input int sel);
    return 32'((sel == 0) ? a_busy : b_busy);
  endfunction
  function automatic logic [31:0] o_done(input int sel);
    return 32'((sel == 0) ? a_done : b_done);
  endfunction
  function automatic logic [31:0] o_ready(input int sel);
    return 32'((sel == 0) ? a_ready : b_ready);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      a_valid = v;
      a_data  = d;
    end else begin
      b_valid = v;
      b_data  = d;
    end
  endtask

  // Idle cycles: both instances must sit quietly on the idle level.
  task automatic idle(input int n);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("idle_outs",  o_outs(s),  32'd1);
        chk("idle_busy",  o_busy(s),  32'd0);
        chk("idle_done",  o_done(s),  32'd0);
        chk("idle_ready", o_ready(s), 32'd1);
      end
    end
  endtask

  // Called at the negedge of the accept cycle. Checks every cycle through
  // completion, scrambling in_valid/in_data while busy. abort_k>0 asserts
  // rst during that cycle and checks the abort behaviour instead.
  task automatic frame(input int sel, input logic [7:0] d, input int abort_k);
    int         tt;
    int         det_obs;
    int         det_exp;
    logic [2:0] h_obs;
    logic [2:0] h_exp;
    tt      = t_done(sel);
    det_obs = 0;
    det_exp = 0;
    h_obs   = 3'b111;
    h_exp   = 3'b111;
    chk("ready_at_accept", o_ready(sel), 32'd1);
    drive(sel, 1'b1, d);
    for (int k = 1; k <= tt; k++) begin
      @(negedge clk);
      chk("outs",       o_outs(sel),  32'(exp_line(sel, d, k)));
      chk("busy",       o_busy(sel),  32'(k < tt));
      chk("frame_done", o_done(sel),  32'(k == tt));
      chk("in_ready",   o_ready(sel), 32'(k == tt));
      h_obs = {h_obs[1:0], o_outs(sel) == 32'd1};
      h_exp = {h_exp[1:0], exp_line(sel, d, k)};
      if (h_obs == 3'b011) det_obs++;
      if (h_exp == 3'b011) det_exp++;
      if (k == abort_k) begin
        rst = 1'b1;
        drive(sel, 1'b0, 8'h00);
        @(negedge clk);
        chk("abort_outs",  o_outs(sel),  32'd1);
        chk("abort_busy",  o_busy(sel),  32'd0);
        chk("abort_done",  o_done(sel),  32'd0);
        chk("abort_ready", o_ready(sel), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_done",  o_done(sel),  32'd0);
        chk("post_abort_ready", o_ready(sel), 32'd1);
        chk("post_abort_outs",  o_outs(sel),  32'd1);
        return;
      end
      if (k < tt) drive(sel, 1'($urandom_range(0, 1)), 8'($urandom));
      else        drive(sel, 1'b0, 8'h00);
    end
    // With one clock per bit the bench's 011 detector sees the line directly.
    if (sel == 1) chk("detector_pulses", 32'(det_obs), 32'(det_exp));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset behaviour
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("rst_outs",  o_outs(s),  32'd1);
        chk("rst_busy",  o_busy(s),  32'd0);
        chk("rst_done",  o_done(s),  32'd0);
        chk("rst_ready", o_ready(s), 32'd0);
      end
    end
    rst = 1'b0;
    idle(2);

    // Directed frames on the default instance
    frame(0, 8'hA5, 0);
    idle(2);
    frame(0, 8'h01, 0);
    idle(1);

    // Back-to-back: second accept lands on the first frame_done cycle
    frame(0, 8'h3C, 0);
    frame(0, 8'hC3, 0);
    idle(1);

    // Abort mid-frame, then a clean frame
    frame(0, 8'($urandom), 20);
    frame(0, 8'($urandom), 0);
    idle(1);

    // One clock per bit, no gap
    frame(1, 8'hFF, 0);
    frame(1, 8'h00, 0);
    idle(1);

    // Randomised frames on both instances
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = i % 2;
      frame(sel, 8'($urandom), 0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
